mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the core's data-memory bus, downstream of the single-cycle RISC-V core.
- Consumes core stores to a TX data address, buffers bytes in a small FIFO, and serialises them 8N1 on tx_o.
- Exposes a combinational status word for polling loads.
- Top level uses Sel_o to steer loads to this block instead of data RAM and to suppress RAM writes.

---
 rtl/mmio_uart_tx.sv | 185 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter that sits on the core's data-memory bus.
//   Stores to TX_DATA_ADDR push Write_Data_i[7:0] into a small circular FIFO.
//   A four-state FSM (IDLE/START/DATA/STOP) pops bytes and shifts them out
//   LSB first on tx_o. Each bit lasts BAUD_DIV clock cycles.
//   Loads from STATUS_ADDR see a combinational status word.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   Mem_Write_i  core store strobe
//   Mem_Read_i   core load strobe (only used to clear the overflow flag)
//   Address_i    ALU result address
//   Write_Data_i store data; only bits [7:0] are transmitted
//   Read_Data_o  status word when Address_i == STATUS_ADDR, else 0
//   Sel_o        1 when Address_i hits either register of this block
//   tx_o         serial output, idle high, registered
//   busy_o       1 while a frame is in flight or bytes are queued
module mmio_uart_tx #(
    parameter int unsigned BAUD_DIV     = 434,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [31:0] TX_DATA_ADDR = 32'h1001_0024,
    parameter logic [31:0] STATUS_ADDR  = 32'h1001_0028
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mem_Write_i,
    input  logic        Mem_Read_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Write_Data_i,
    output logic [31:0] Read_Data_o,
    output logic        Sel_o,
    output logic        tx_o,
    output logic        busy_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // The count must be able to hold FIFO_DEPTH itself.
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [15:0]   RELOAD  = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           ovf_q, ovf_d;

    logic [7:0]     mem [FIFO_DEPTH];

    logic           addr_tx, addr_st;
    logic           full, empty;
    logic           push_req, push, pop;

    // Only the low byte of the store data is transmitted.
    logic           unused_wdata;
    assign unused_wdata = ^Write_Data_i[31:8];

    assign addr_tx  = (Address_i == TX_DATA_ADDR);
    assign addr_st  = (Address_i == STATUS_ADDR);
    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign push_req = Mem_Write_i & addr_tx;
    // A full FIFO drops the byte even if a pop frees a slot on this edge.
    assign push     = push_req & ~full;
    assign pop      = (state_q == IDLE) & ~empty;

    assign Sel_o       = addr_tx | addr_st;
    assign busy_o      = (state_q != IDLE) | ~empty;
    assign tx_o        = tx_q;
    assign Read_Data_o = addr_st ? {23'b0, 5'(count_q), ovf_q, busy_o, empty, full}
                                 : 32'b0;

    // FIFO storage: no reset, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= Write_Data_i[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (Mem_Read_i && addr_st) begin
            ovf_d = 1'b0;
        end
        // Set is applied last so it wins over a clear on the same edge.
        if (push_req && full) begin
            ovf_d = 1'b1;
        end
    end

    // Transmit FSM next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d = mem[rd_ptr_q];
                    cnt_d   = RELOAD;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == 16'd0) begin
                    cnt_d     = RELOAD;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == 16'd0) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    cnt_d   = RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == 16'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // The line level is derived from the next state so that tx_o
        // comes straight from a flop and still tracks the FSM cycle-exactly.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed testbench for mmio_uart_tx with BAUD_DIV=4 and FIFO_DEPTH=8.
module tb_mmio_uart_tx;

    localparam logic [31:0] TX_ADDR = 32'h1001_0024;
    localparam logic [31:0] ST_ADDR = 32'h1001_0028;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        sel;
    logic        tx;
    logic        busy;

    int errors = 0;
    int checks = 0;

    mmio_uart_tx #(
        .BAUD_DIV     (4),
        .FIFO_DEPTH   (8),
        .TX_DATA_ADDR (TX_ADDR),
        .STATUS_ADDR  (ST_ADDR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Mem_Write_i  (mem_write),
        .Mem_Read_i   (mem_read),
        .Address_i    (addr),
        .Write_Data_i (wdata),
        .Read_Data_o  (rdata),
        .Sel_o        (sel),
        .tx_o         (tx),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bit index 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Called at the sample for frame cycle j0; returns at the sample of cycle 39.
    task automatic expect_frame(input logic [7:0] b, input int j0);
        for (int j = j0; j < 40; j++) begin
            check($sformatf("tx byte %02h cyc %0d", b, j), {31'b0, tx},
                  {31'b0, frame_bit(b, j / 4)});
            if (j < 39) step();
        end
        $display("frame 0x%02h serialised", b);
    endtask

    logic saw_low;

    initial begin
        // 1. reset
        addr = ST_ADDR;
        repeat (3) @(posedge clk);
        #1;
        check("tx in reset", {31'b0, tx}, 32'd1);
        reset = 1'b1;
        step();
        check("tx after reset", {31'b0, tx}, 32'd1);
        check("busy after reset", {31'b0, busy}, 32'd0);
        check("status after reset", rdata, 32'h0000_0002);
        check("sel status addr", {31'b0, sel}, 32'd1);
        $display("reset released, status=%h", rdata);

        // 5. store to an unrelated address, then a store to STATUS_ADDR
        addr = 32'h1001_0020; wdata = 32'h0000_00A5; mem_write = 1'b1;
        #1;
        check("sel other addr", {31'b0, sel}, 32'd0);
        check("rdata other addr", rdata, 32'h0);
        step();
        addr = ST_ADDR; wdata = 32'h0000_0011;
        step();
        mem_write = 1'b0;
        #1;
        check("status no push", rdata, 32'h0000_0002);
        check("tx idle no push", {31'b0, tx}, 32'd1);
        addr = TX_ADDR;
        #1;
        check("sel tx addr", {31'b0, sel}, 32'd1);
        check("rdata tx addr", rdata, 32'h0);
        $display("stray stores ignored");

        // 2. single frame of 0x55
        wdata = 32'hFFFF_FF55; mem_write = 1'b1;
        step();
        mem_write = 1'b0;
        check("tx still high at push", {31'b0, tx}, 32'd1);
        check("busy at push", {31'b0, busy}, 32'd1);
        step();
        expect_frame(8'h55, 0);
        check("busy end of stop", {31'b0, busy}, 32'd1);
        step();
        check("busy after frame", {31'b0, busy}, 32'd0);
        addr = ST_ADDR;
        #1;
        check("status after frame", rdata, 32'h0000_0002);

        // 3. ten back-to-back stores, 0x09 overflows
        addr = TX_ADDR; mem_write = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wdata = 32'(i);
            step();
            if (i >= 1) begin
                check($sformatf("tx byte 00 cyc %0d", i - 1), {31'b0, tx},
                      {31'b0, frame_bit(8'h00, (i - 1) / 4)});
            end
        end
        mem_write = 1'b0; addr = ST_ADDR;
        #1;
        check("status full+ovf", rdata, 32'h0000_008D);
        step();
        expect_frame(8'h00, 9);
        for (int b = 1; b <= 8; b++) begin
            step();
            check($sformatf("gap before %02h", b), {31'b0, tx}, 32'd1);
            step();
            expect_frame(8'(b), 0);
        end
        step();
        check("busy after drain", {31'b0, busy}, 32'd0);
        check("status drained ovf", rdata, 32'h0000_000A);

        // 4. overflow clear rules
        mem_read = 1'b1; addr = TX_ADDR;
        step();
        mem_read = 1'b0; addr = ST_ADDR;
        #1;
        check("ovf kept on tx-addr read", rdata, 32'h0000_000A);
        mem_read = 1'b1;
        step();
        mem_read = 1'b0;
        #1;
        check("ovf cleared", rdata, 32'h0000_0002);
        $display("overflow cleared by status load");

        addr = TX_ADDR; wdata = 32'h0; mem_write = 1'b1;
        for (int i = 0; i < 9; i++) step();
        mem_read = 1'b1;
        step();
        mem_write = 1'b0; mem_read = 1'b0; addr = ST_ADDR;
        #1;
        check("ovf set with read strobe", rdata, 32'h0000_008D);
        mem_read = 1'b1;
        step();
        mem_read = 1'b0;
        #1;
        check("ovf clear while full", rdata, 32'h0000_0085);
        check("tx in data bit", {31'b0, tx}, 32'd0);

        // 6. asynchronous reset mid data bit
        #2;
        reset = 1'b0;
        #1;
        check("tx on async reset", {31'b0, tx}, 32'd1);
        check("busy on async reset", {31'b0, busy}, 32'd0);
        check("status on async reset", rdata, 32'h0000_0002);
        @(posedge clk);
        #1;
        reset = 1'b1;
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tx !== 1'b1) saw_low = 1'b1;
        end
        check("no frame after reset", {31'b0, saw_low}, 32'd0);
        check("busy after reset pulse", {31'b0, busy}, 32'd0);
        check("status after reset pulse", rdata, 32'h0000_0002);
        $display("mid-frame reset abandoned frame");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
